// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV64 control FSM: sequences memory, ALU and register file per instruction.
// Optional MULTICYCLE_PERF_EN adds cycle_cnt_o / instret_o performance counters.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned STATE_W     = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [6:0]         opcode_i,
   input  logic               mem_ready_i,
   output logic               mem_req_o,
   output logic               mem_we_o,
   output logic               i_or_d_o,
   output logic               ir_write_o,
   output logic               pc_write_o,
   output logic               pc_write_cond_o,
   output logic [1:0]         pc_source_o,
   output logic [1:0]         alu_src_a_o,
   output logic [1:0]         alu_src_b_o,
   output logic [1:0]         alu_op_o,
   output logic               reg_write_o,
   output logic               mem_to_reg_o,
   output logic [STATE_W-1:0] state_o,
   output logic               halt_o,
   output logic [1:0]         err_code_o
`ifdef MULTICYCLE_PERF_EN
   ,
   output logic [31:0]        cycle_cnt_o,
   output logic [31:0]        instret_o
`endif
);

   localparam int unsigned CNT_W = 8;

   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_WB_MEM   = 4'd6,
      S_EXEC_R   = 4'd7,
      S_EXEC_I   = 4'd8,
      S_WB_ALU   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JAL      = 4'd11,
      S_HALT     = 4'd15
   } state_t;

   state_t             state, next_state;
   logic [CNT_W-1:0]   to_cnt;
   logic [1:0]         err_q, err_next;
   logic               mem_state;
   logic               timeout;

   // A memory state gives up only if ready is still low once the wait count hits the limit
   assign mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
   assign timeout   = mem_state && !mem_ready_i && (to_cnt == CNT_W'(MEM_TIMEOUT));

   assign state_o    = STATE_W'(state);
   assign err_code_o = err_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= S_IDLE;
      else        state <= next_state;
   end

   // Wait counter restarts on every memory-state entry because leaving one needs ready
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         to_cnt <= '0;
         err_q  <= 2'b00;
      end else begin
         err_q <= err_next;
         if (mem_state && !mem_ready_i && !timeout) to_cnt <= to_cnt + CNT_W'(1);
         else                                       to_cnt <= '0;
      end
   end

   always_comb begin
      next_state      = state;
      err_next        = err_q;
      mem_req_o       = 1'b0;
      mem_we_o        = 1'b0;
      i_or_d_o        = 1'b0;
      ir_write_o      = 1'b0;
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      pc_source_o     = 2'b00;
      alu_src_a_o     = 2'b00;
      alu_src_b_o     = 2'b00;
      alu_op_o        = 2'b00;
      reg_write_o     = 1'b0;
      mem_to_reg_o    = 1'b0;
      halt_o          = 1'b0;

      case (state)
         S_IDLE: next_state = S_FETCH;
         S_FETCH: begin
            mem_req_o   = 1'b1;
            alu_src_b_o = 2'b01;
            if (mem_ready_i) begin
               ir_write_o = 1'b1;
               pc_write_o = 1'b1;
               next_state = S_DECODE;
            end else if (timeout) begin
               next_state = S_HALT;
            end
         end
         S_DECODE: begin
            alu_src_a_o = 2'b10;
            alu_src_b_o = 2'b10;
            case (opcode_i)
               OP_LD, OP_SD: next_state = S_MEM_ADDR;
               OP_R:         next_state = S_EXEC_R;
               OP_I:         next_state = S_EXEC_I;
               OP_BR:        next_state = S_BRANCH;
               OP_JAL:       next_state = S_JAL;
               default: begin
                  next_state = S_HALT;
                  err_next   = 2'b01;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b10;
            next_state  = (opcode_i == OP_SD) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_req_o = 1'b1;
            i_or_d_o  = 1'b1;
            if (mem_ready_i)  next_state = S_WB_MEM;
            else if (timeout) next_state = S_HALT;
         end
         S_MEM_WR: begin
            mem_req_o = 1'b1;
            mem_we_o  = 1'b1;
            i_or_d_o  = 1'b1;
            if (mem_ready_i)  next_state = S_FETCH;
            else if (timeout) next_state = S_HALT;
         end
         S_WB_MEM: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = 1'b1;
            next_state   = S_FETCH;
         end
         S_EXEC_R: begin
            alu_src_a_o = 2'b01;
            alu_op_o    = 2'b10;
            next_state  = S_WB_ALU;
         end
         S_EXEC_I: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b10;
            alu_op_o    = 2'b11;
            next_state  = S_WB_ALU;
         end
         S_WB_ALU: begin
            reg_write_o = 1'b1;
            next_state  = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a_o     = 2'b01;
            alu_op_o        = 2'b01;
            pc_write_cond_o = 1'b1;
            pc_source_o     = 2'b01;
            next_state      = S_FETCH;
         end
         S_JAL: begin
            reg_write_o = 1'b1;
            pc_write_o  = 1'b1;
            pc_source_o = 2'b10;
            next_state  = S_FETCH;
         end
         S_HALT:  halt_o = 1'b1;
         default: next_state = S_HALT;
      endcase

      if (timeout) err_next = 2'b10;
   end

`ifdef MULTICYCLE_PERF_EN
   logic retire;

   // Retirement is the hand-back to FETCH from a state that completes an instruction
   assign retire = (next_state == S_FETCH) &&
                   ((state == S_WB_ALU) || (state == S_WB_MEM) || (state == S_MEM_WR) ||
                    (state == S_BRANCH) || (state == S_JAL));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cycle_cnt_o <= '0;
         instret_o   <= '0;
      end else begin
         if (state != S_HALT) cycle_cnt_o <= cycle_cnt_o + 32'd1;
         if (retire)          instret_o   <= instret_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a per-instruction cycle-trace model drives mem_ready_i
// and supplies the expected state/strobes for every cycle.
module tb_multicycle_ctrl;

   localparam int unsigned T = 4;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [6:0]  opcode_i = 7'd0;
   logic        mem_ready_i = 1'b0;
   logic        mem_req_o, mem_we_o, i_or_d_o, ir_write_o, pc_write_o, pc_write_cond_o;
   logic [1:0]  pc_source_o, alu_src_a_o, alu_src_b_o, alu_op_o, err_code_o;
   logic        reg_write_o, mem_to_reg_o, halt_o;
   logic [3:0]  state_o;
`ifdef MULTICYCLE_PERF_EN
   logic [31:0] cycle_cnt_o, instret_o;
`endif

   multicycle_ctrl #(.MEM_TIMEOUT(T), .STATE_W(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .i_or_d_o(i_or_d_o),
      .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o),
      .pc_source_o(pc_source_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
      .alu_op_o(alu_op_o), .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
      .state_o(state_o), .halt_o(halt_o), .err_code_o(err_code_o)
`ifdef MULTICYCLE_PERF_EN
      , .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   logic [18:0] outs;
   assign outs = {mem_req_o, mem_we_o, i_or_d_o, ir_write_o, pc_write_o, pc_write_cond_o,
                  pc_source_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                  reg_write_o, mem_to_reg_o, halt_o, err_code_o};

   typedef struct {
      logic [3:0] st;
      logic       rdy;
      logic [6:0] op;
      logic [1:0] err;
      bit         done;
   } ent_t;

   ent_t       trace[$];
   logic [1:0] cur_err;
   int         n_chk = 0;
   int         n_fail = 0;
   int         exp_cyc = 0;
   int         exp_ret = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Strobe table: what each state must present, straight from the state descriptions
   function automatic logic [18:0] exp_out(input logic [3:0] st, input logic rdy,
                                           input logic [1:0] err);
      logic req, we, iord, irw, pcw, pwc, rw, m2r, hlt;
      logic [1:0] ps, a, b, op;
      {req, we, iord, irw, pcw, pwc, rw, m2r, hlt} = '0;
      {ps, a, b, op} = '0;
      case (st)
         4'd1:  begin req = 1; b = 2'b01; irw = rdy; pcw = rdy; end
         4'd2:  begin a = 2'b10; b = 2'b10; end
         4'd3:  begin a = 2'b01; b = 2'b10; end
         4'd4:  begin req = 1; iord = 1; end
         4'd5:  begin req = 1; we = 1; iord = 1; end
         4'd6:  begin rw = 1; m2r = 1; end
         4'd7:  begin a = 2'b01; op = 2'b10; end
         4'd8:  begin a = 2'b01; b = 2'b10; op = 2'b11; end
         4'd9:  rw = 1;
         4'd10: begin a = 2'b01; op = 2'b01; pwc = 1; ps = 2'b01; end
         4'd11: begin rw = 1; pcw = 1; ps = 2'b10; end
         4'd15: hlt = 1;
         default: ;
      endcase
      return {req, we, iord, irw, pcw, pwc, ps, a, b, op, rw, m2r, hlt, err};
   endfunction

   task automatic push(input logic [3:0] st, input logic rdy, input logic [6:0] op,
                       input bit done);
      ent_t e;
      e.st = st; e.rdy = rdy; e.op = op; e.err = cur_err; e.done = done;
      trace.push_back(e);
   endtask

   task automatic push_halt(input logic [6:0] op);
      for (int k = 0; k < 20; k++) push(4'd15, 1'($urandom), op, 0);
   endtask

   // Memory access: 'waits' low-ready cycles then ready, or timeout once waits exceed the limit
   task automatic gen_mem(input logic [3:0] st, input int waits, input logic [6:0] op,
                          input bit done_on_rdy, output bit dead);
      dead = 0;
      if (waits > int'(T)) begin
         for (int k = 0; k <= int'(T); k++) push(st, 1'b0, op, 0);
         cur_err = 2'b10;
         push_halt(op);
         dead = 1;
      end else begin
         for (int k = 0; k < waits; k++) push(st, 1'b0, op, 0);
         push(st, 1'b1, op, done_on_rdy);
      end
   endtask

   // kind: 0 LD, 1 SD, 2 R, 3 I, 4 BR, 5 JAL, 6 illegal
   task automatic gen_instr(input int kind, input int wf, input int wm, input logic [6:0] ill,
                            output bit dead);
      logic [6:0] op;
      case (kind)
         0: op = 7'b0000011;
         1: op = 7'b0100011;
         2: op = 7'b0110011;
         3: op = 7'b0010011;
         4: op = 7'b1100011;
         5: op = 7'b1101111;
         default: op = ill;
      endcase
      gen_mem(4'd1, wf, op, 0, dead);
      if (dead) return;
      push(4'd2, 1'($urandom), op, 0);
      case (kind)
         0: begin
            push(4'd3, 1'($urandom), op, 0);
            gen_mem(4'd4, wm, op, 0, dead);
            if (!dead) push(4'd6, 1'($urandom), op, 1);
         end
         1: begin
            push(4'd3, 1'($urandom), op, 0);
            gen_mem(4'd5, wm, op, 1, dead);
         end
         2: begin push(4'd7, 1'($urandom), op, 0); push(4'd9, 1'($urandom), op, 1); end
         3: begin push(4'd8, 1'($urandom), op, 0); push(4'd9, 1'($urandom), op, 1); end
         4: push(4'd10, 1'($urandom), op, 1);
         5: push(4'd11, 1'($urandom), op, 1);
         default: begin
            cur_err = 2'b01;
            push_halt(op);
            dead = 1;
         end
      endcase
   endtask

   function automatic logic [6:0] rand_illegal();
      logic [6:0] op;
      do op = 7'($urandom);
      while (op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                        7'b1101111});
      return op;
   endfunction

   function automatic int rand_wait();
      int r;
      r = $urandom_range(0, 19);
      if (r < 14) return r % 4;
      if (r < 18) return int'(T);
      return int'(T) + 1 + (r & 1);
   endfunction

   task automatic start_ep();
      cur_err = 2'b00;
      trace.delete();
      push(4'd0, 1'($urandom), 7'd0, 0);
   endtask

   // Called just after a negedge; outputs must collapse to IDLE values without a clock edge
   task automatic do_reset();
      rst_i = 1'b0;
      mem_ready_i = 1'b0;
      #1;
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_outs", 32'(outs), 32'd0);
`ifdef MULTICYCLE_PERF_EN
      chk("rst_cyc", cycle_cnt_o, 32'd0);
      chk("rst_ret", instret_o, 32'd0);
`endif
      repeat (2) @(posedge clk_i);
      #2 rst_i = 1'b1;
      exp_cyc = 0;
      exp_ret = 0;
   endtask

   task automatic run_trace();
      foreach (trace[i]) begin
         @(negedge clk_i);
         mem_ready_i = trace[i].rdy;
         opcode_i    = trace[i].op;
         #1;
         chk("state", 32'(state_o), 32'(trace[i].st));
         chk("outs", 32'(outs), 32'(exp_out(trace[i].st, trace[i].rdy, trace[i].err)));
`ifdef MULTICYCLE_PERF_EN
         chk("cycle_cnt", cycle_cnt_o, 32'(exp_cyc));
         chk("instret", instret_o, 32'(exp_ret));
`endif
         if (trace[i].st != 4'd15) exp_cyc++;
         if (trace[i].done) exp_ret++;
      end
   endtask

   task automatic episode(input int kind, input int wf, input int wm, input logic [6:0] ill);
      bit dead;
      start_ep();
      gen_instr(kind, wf, wm, ill, dead);
      if (!dead) begin
         push(4'd1, 1'b0, 7'd0, 0);
      end
      @(negedge clk_i);
      do_reset();
      run_trace();
   endtask

   initial begin
      bit dead;
      // Directed: R zero-wait, LD with 2 waits, BEQ, illegal, fetch timeout, ready on limit
      episode(2, 0, 0, 7'd0);
      episode(0, 0, 2, 7'd0);
      episode(4, 0, 0, 7'd0);
      episode(6, 0, 0, 7'b1111111);
      episode(2, int'(T) + 1, 0, 7'd0);
      episode(2, int'(T), 0, 7'd0);
      episode(1, 1, int'(T) + 1, 7'd0);
      episode(0, 0, int'(T), 7'd0);

      // Reset asserted while a store is waiting on memory
      start_ep();
      gen_instr(1, 0, 3, 7'd0, dead);
      void'(trace.pop_back());
      void'(trace.pop_back());
      @(negedge clk_i);
      do_reset();
      run_trace();
      @(negedge clk_i);
      mem_ready_i = 1'b0;
      #1;
      chk("pre_rst_state", 32'(state_o), 32'd5);
      chk("pre_rst_req", 32'(mem_req_o), 32'd1);
      do_reset();
      start_ep();
      gen_instr(3, 0, 0, 7'd0, dead);
      run_trace();

      // Random instruction streams
      for (int ep = 0; ep < 40; ep++) begin
         int n;
         start_ep();
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) begin
            int kind;
            kind = ($urandom_range(0, 19) == 0) ? 6 : int'($urandom_range(0, 5));
            gen_instr(kind, rand_wait(), rand_wait(), rand_illegal(), dead);
            if (dead) break;
         end
         @(negedge clk_i);
         do_reset();
         run_trace();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
